rr_arb8_ctrl: RTL and testbench



---
 rtl/arb_pkg.sv | 35 +++
 rtl/dec3to8_en.sv | 29 ++
 rtl/rr_arb8_ctrl.sv | 107 ++++++++++
 tb/tb_rr_arb8_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, FSM states
// and the rotating-priority winner search.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } state_t;

  // First set request bit searching ptr, ptr+1, ... ptr+7 (wrapping).
  // Returns 0 when no bit is set; callers only use it when |req is true.
  function automatic logic [IDX_W-1:0] next_rr(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_win;
    logic             w_found;
    w_win   = {IDX_W{1'b0}};
    w_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = ptr + k[IDX_W-1:0];
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end else begin
        w_found = w_found;
      end
    end
    return w_win;
  endfunction

endpackage

// File: rtl/dec3to8_en.sv
// Combinational 3-to-8 decoder with enable; drives the one-hot grant from
// the registered index so the one-hot can never carry more than one bit.
module dec3to8_en (
  input  logic [2:0] i_idx,
  input  logic       i_en,
  output logic [7:0] o_onehot
);

  // Decode the index into a single set bit, all-zero when disabled.
  always_comb begin
    o_onehot = 8'h00;
    if (i_en) begin
      case (i_idx)
        3'd0:    o_onehot = 8'h01;
        3'd1:    o_onehot = 8'h02;
        3'd2:    o_onehot = 8'h04;
        3'd3:    o_onehot = 8'h08;
        3'd4:    o_onehot = 8'h10;
        3'd5:    o_onehot = 8'h20;
        3'd6:    o_onehot = 8'h40;
        3'd7:    o_onehot = 8'h80;
        default: o_onehot = 8'h00;
      endcase
    end else begin
      o_onehot = 8'h00;
    end
  end

endmodule

// File: rtl/rr_arb8_ctrl.sv
// Round-robin arbiter for eight masters sharing the 3-to-8 decode resource.
// IDLE picks an owner, BUSY holds it until done / request drop / hold limit,
// TURN inserts one dead cycle before the next arbitration.
module rr_arb8_ctrl
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] grant_onehot,
  output logic             timeout
);

  localparam logic             LIMIT_EN  = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_grant_valid;
  logic [IDX_W-1:0] r_grant_idx;
  logic             r_timeout;

  logic [IDX_W-1:0] w_winner;
  logic             w_owner_req;
  logic             w_limit;
  logic             w_release;

  // Release decode for the current tenure and the next rotating winner.
  always_comb begin
    w_winner    = next_rr(req, r_ptr);
    w_owner_req = req[r_grant_idx];
    w_limit     = LIMIT_EN && (r_hold_cnt == HOLD_LAST);
    w_release   = done || !w_owner_req || w_limit;
  end

  // Arbitration FSM with registered grant, pointer, hold counter and timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ptr         <= {IDX_W{1'b0}};
      r_hold_cnt    <= {CNT_W{1'b0}};
      r_grant_valid <= 1'b0;
      r_grant_idx   <= {IDX_W{1'b0}};
      r_timeout     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_timeout <= 1'b0;
          if (|req) begin
            r_state       <= BUSY;
            r_grant_valid <= 1'b1;
            r_grant_idx   <= w_winner;
            r_hold_cnt    <= {CNT_W{1'b0}};
          end else begin
            r_grant_valid <= 1'b0;
            r_grant_idx   <= {IDX_W{1'b0}};
          end
        end
        BUSY: begin
          if (w_release) begin
            r_state       <= TURN;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= {IDX_W{1'b0}};
            r_ptr         <= r_grant_idx + 3'd1;
            r_hold_cnt    <= {CNT_W{1'b0}};
            // Forced release only when neither done nor a request drop also ended it.
            r_timeout     <= w_limit && !done && w_owner_req;
          end else begin
            r_hold_cnt    <= r_hold_cnt + CNT_W'(1);
            r_timeout     <= 1'b0;
          end
        end
        TURN: begin
          r_state       <= IDLE;
          r_grant_valid <= 1'b0;
          r_grant_idx   <= {IDX_W{1'b0}};
          r_timeout     <= 1'b0;
        end
        default: begin
          r_state       <= IDLE;
          r_grant_valid <= 1'b0;
          r_grant_idx   <= {IDX_W{1'b0}};
          r_hold_cnt    <= {CNT_W{1'b0}};
          r_timeout     <= 1'b0;
        end
      endcase
    end
  end

  dec3to8_en u_dec (
    .i_idx    (r_grant_idx),
    .i_en     (r_grant_valid),
    .o_onehot (grant_onehot)
  );

  assign grant_valid = r_grant_valid;
  assign grant_idx   = r_grant_idx;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Self-checking bench for rr_arb8_ctrl: a cycle model pushes the expected
// outputs into a scoreboard queue at every rising edge; a monitor pops and
// compares on the falling edge. Directed scenario checks run on top.
module tb_rr_arb8_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic [7:0] grant_onehot;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       v;
    logic [2:0] idx;
    logic [7:0] oh;
    logic       to;
  } exp_t;

  exp_t       sb_q[$];
  logic [2:0] grant_log[$];

  rr_arb8_ctrl #(.MAX_HOLD(16), .CNT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .done         (done),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: behaviour of the arbiter written from the state description.
  int         m_state = 0;  // 0 idle, 1 busy, 2 turn
  logic [2:0] m_ptr   = 3'd0;
  int         m_cnt   = 0;
  logic [2:0] m_owner = 3'd0;
  logic       m_valid = 1'b0;
  logic       m_to    = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    logic lim;
    if (rst === 1'b1) begin
      m_state = 0; m_ptr = 3'd0; m_cnt = 0; m_owner = 3'd0; m_valid = 1'b0; m_to = 1'b0;
    end else if (m_state == 0) begin
      m_to = 1'b0;
      if (req != 8'h00) begin
        for (int k = 7; k >= 0; k--) begin
          if (req[(int'(m_ptr) + k) % 8]) m_owner = 3'((int'(m_ptr) + k) % 8);
        end
        m_valid = 1'b1; m_cnt = 0; m_state = 1;
      end
    end else if (m_state == 1) begin
      lim = (m_cnt == 15);
      if (done || !req[m_owner] || lim) begin
        m_to    = lim && !done && req[m_owner];
        m_ptr   = 3'((int'(m_owner) + 1) % 8);
        m_valid = 1'b0;
        m_state = 2;
      end else begin
        m_cnt++;
      end
    end else begin
      m_to = 1'b0; m_state = 0;
    end
    e.v   = m_valid;
    e.idx = m_valid ? m_owner : 3'd0;
    e.oh  = m_valid ? (8'h01 << m_owner) : 8'h00;
    e.to  = m_to;
    sb_q.push_back(e);
  end

  // Monitor: compare against the scoreboard and log each new grant.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("sb_valid",   32'(grant_valid),  32'(e.v));
      check_eq("sb_idx",     32'(grant_idx),    32'(e.idx));
      check_eq("sb_onehot",  32'(grant_onehot), 32'(e.oh));
      check_eq("sb_timeout", 32'(timeout),      32'(e.to));
    end
    if (grant_valid === 1'b1 && prev_valid !== 1'b1) grant_log.push_back(grant_idx);
    prev_valid = grant_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag, input int max, output int cycles);
    cycles = 0;
    while (grant_valid !== 1'b1 && cycles < max) begin
      tick();
      cycles++;
    end
    if (grant_valid !== 1'b1) check_eq({tag, "_wait"}, 32'd0, 32'd1);
  endtask

  initial begin
    int c;
    int hold;
    rst = 1'b1; req = 8'hFF; done = 1'b0;

    // Reset with all requests set.
    repeat (2) tick();
    check_eq("rst_valid",  32'(grant_valid),  32'd0);
    check_eq("rst_onehot", 32'(grant_onehot), 32'd0);
    check_eq("rst_to",     32'(timeout),      32'd0);
    rst = 1'b0;
    tick();
    check_eq("first_valid", 32'(grant_valid), 32'd1);
    check_eq("first_idx",   32'(grant_idx),   32'd0);
    done = 1'b1; tick(); done = 1'b0; req = 8'h00;
    repeat (3) tick();

    // Single requester with done, then regrant after the turnaround.
    req = 8'h20;
    wait_grant("single", 10, c);
    check_eq("single_idx",    32'(grant_idx),    32'd5);
    check_eq("single_onehot", 32'(grant_onehot), 32'h20);
    done = 1'b1; tick(); done = 1'b0;
    check_eq("turn_valid", 32'(grant_valid), 32'd0);
    tick();
    check_eq("idle_valid", 32'(grant_valid), 32'd0);
    tick();
    check_eq("regrant_valid", 32'(grant_valid), 32'd1);
    check_eq("regrant_idx",   32'(grant_idx),   32'd5);
    req = 8'h00; done = 1'b1; tick(); done = 1'b0;
    repeat (2) tick();

    // Round robin from a fresh pointer.
    rst = 1'b1; tick(); rst = 1'b0;
    grant_log.delete();
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      wait_grant("rr", 10, c);
      if (i > 0) check_eq("rr_gap", 32'(c), 32'd2);
      done = 1'b1; tick(); done = 1'b0;
    end
    req = 8'h00;
    repeat (2) tick();
    check_eq("rr_count", 32'(grant_log.size()), 32'd9);
    for (int i = 0; i < 9 && i < grant_log.size(); i++)
      check_eq($sformatf("rr_order%0d", i), 32'(grant_log[i]), 32'(i % 8));

    // Hold limit with done never asserted.
    req = 8'h01;
    wait_grant("to", 10, c);
    hold = 0;
    while (grant_valid === 1'b1 && hold < 40) begin
      hold++;
      tick();
    end
    check_eq("to_hold_len", 32'(hold),    32'd16);
    check_eq("to_pulse",    32'(timeout), 32'd1);
    tick();
    check_eq("to_pulse_end", 32'(timeout), 32'd0);
    tick();
    check_eq("to_regrant_valid", 32'(grant_valid), 32'd1);
    check_eq("to_regrant_idx",   32'(grant_idx),   32'd0);

    // done coinciding with the hold limit: normal release, pointer advances.
    repeat (15) tick();
    done = 1'b1; req = 8'h03; tick(); done = 1'b0;
    check_eq("sim_done_valid", 32'(grant_valid), 32'd0);
    check_eq("sim_done_to",    32'(timeout),     32'd0);
    repeat (2) tick();
    check_eq("sim_done_next", 32'(grant_idx), 32'd1);

    // Owner request drop coinciding with the hold limit.
    repeat (15) tick();
    req = 8'h01; tick();
    check_eq("sim_drop_valid", 32'(grant_valid), 32'd0);
    check_eq("sim_drop_to",    32'(timeout),     32'd0);
    repeat (2) tick();
    check_eq("sim_drop_next", 32'(grant_idx), 32'd0);
    req = 8'h00; repeat (3) tick();

    // Reset in the middle of a grant, with the pointer moved past agent 3.
    req = 8'h08;
    wait_grant("mid", 10, c);
    done = 1'b1; tick(); done = 1'b0;
    wait_grant("mid2", 10, c);
    tick();
    rst = 1'b1; tick();
    check_eq("midrst_valid",  32'(grant_valid),  32'd0);
    check_eq("midrst_idx",    32'(grant_idx),    32'd0);
    check_eq("midrst_onehot", 32'(grant_onehot), 32'd0);
    rst = 1'b0; req = 8'h18; tick();
    check_eq("midrst_regrant_valid", 32'(grant_valid), 32'd1);
    check_eq("midrst_regrant_idx",   32'(grant_idx),   32'd3);
    req = 8'h00;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
